controla_saida: RTL

- Exit-lane controller for the parking gate system; the counterpart of the entry flow controller.
- Sequences a vehicle leaving through the exit sensors (inner SIs, outer SEs) and drives the exit gate outputs.
- Owns the occupancy counter: increments on the entry controller's completed-entry pulse, decrements on each completed exit.
- Generates the registered Full flag that the entry controller consumes.

---
 rtl/controla_saida.sv | 104 ++++++++++
 1 files changed

// File: rtl/controla_saida.sv
// controla_saida: exit-lane FSM with occupancy counter and Full flag; SAIDA_TIMEOUT_EN adds a Liberando watchdog.
module controla_saida #(
  parameter int VAGAS   = 8,
  parameter int CNT_W   = 4,
  parameter int TIMEOUT = 50,
  parameter int TIMER_W = 8
) (
  input  logic             Clock,
  input  logic             reset,
  input  logic             SIs,
  input  logic             SEs,
  input  logic             Entrou,
  output logic             Liberado,
  output logic             Pare,
  output logic             Saiu,
  output logic             Anomalia,
  output logic             Full,
  output logic [CNT_W-1:0] Ocupacao,
  output logic             Timeout,
  output logic [2:0]       state
);
  typedef enum logic [2:0] {
    INICIAL    = 3'd0,
    LIBERANDO  = 3'd1,
    PARE_SAIDA = 3'd2,
    SAINDO     = 3'd3,
    CONCLUIDO  = 3'd4
  } state_t;

  if (VAGAS > 2**CNT_W - 1) begin : g_bad_cnt
    $error("VAGAS does not fit in CNT_W bits");
  end
  if (TIMEOUT > 2**TIMER_W || TIMEOUT < 1) begin : g_bad_tmr
    $error("TIMEOUT out of range for TIMER_W");
  end

  state_t           r_state;
  state_t           w_next;
  logic             w_empty;
  logic             w_dec;
  logic             w_to;
  logic [CNT_W-1:0] w_occ_nx;

`ifdef SAIDA_TIMEOUT_EN
  logic [TIMER_W-1:0] r_tmr;
`endif

  assign state = r_state;

  always_comb begin
    w_empty = Ocupacao == '0;
    w_to    = 1'b0;
    case (r_state)
      INICIAL:               w_next = (SIs && !SEs && !w_empty) ? LIBERANDO : INICIAL;
      LIBERANDO:             w_next = SEs ? (SIs ? PARE_SAIDA : SAINDO) : (SIs ? LIBERANDO : INICIAL);
      PARE_SAIDA, SAINDO:    w_next = SEs ? (SIs ? PARE_SAIDA : SAINDO) : (SIs ? LIBERANDO : CONCLUIDO);
      default:               w_next = INICIAL;
    endcase
`ifdef SAIDA_TIMEOUT_EN
    w_to   = r_state == LIBERANDO && w_next == LIBERANDO && r_tmr == TIMER_W'(TIMEOUT - 1);
    w_next = w_to ? INICIAL : w_next;
`endif
    w_dec    = w_next == CONCLUIDO;
    // a simultaneous entry and exit cancel out
    w_occ_nx = (Entrou && !w_dec) ? ((Ocupacao == CNT_W'(VAGAS)) ? Ocupacao : Ocupacao + CNT_W'(1)) :
               (w_dec && !Entrou) ? (w_empty ? Ocupacao : Ocupacao - CNT_W'(1)) : Ocupacao;
  end

  always_ff @(posedge Clock) begin
    if (reset) begin
      r_state  <= INICIAL;
      Liberado <= 1'b0;
      Pare     <= 1'b0;
      Saiu     <= 1'b0;
      Anomalia <= 1'b0;
      Full     <= 1'b0;
      Ocupacao <= '0;
    end else begin
      r_state  <= w_next;
      Liberado <= w_next == LIBERANDO || w_next == PARE_SAIDA || w_next == SAINDO;
      Pare     <= w_next == PARE_SAIDA;
      Saiu     <= w_dec;
      Anomalia <= r_state == INICIAL && SIs && w_empty;
      Full     <= w_occ_nx == CNT_W'(VAGAS);
      Ocupacao <= w_occ_nx;
    end
  end

`ifdef SAIDA_TIMEOUT_EN
  always_ff @(posedge Clock) begin
    if (reset) begin
      r_tmr   <= '0;
      Timeout <= 1'b0;
    end else begin
      r_tmr   <= (r_state == LIBERANDO && w_next == LIBERANDO) ? r_tmr + TIMER_W'(1) : '0;
      Timeout <= w_to;
    end
  end
`else
  assign Timeout = 1'b0;
  logic w_unused;
  assign w_unused = w_to;
`endif
endmodule
